program_memory_loader: RTL and testbench



---
 rtl/program_memory_loader.sv | 195 +++++++++++++++++++
 tb/tb_program_memory_loader.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_memory_loader.sv
// program_memory_loader
//
// Fills the RV32I instruction memory from a framed byte stream before the core
// runs. Frame: N[7:0], N[15:8], then 4*N bytes forming N little-endian words.
// Each completed word produces a one-cycle write to program memory. The core is
// held in reset until the full image has been written.
//
// Optional feature (macro LOADER_CHECKSUM_EN): a trailing checksum byte follows
// the data. It must equal the XOR of all data bytes; otherwise the frame is
// rejected. Leave the macro undefined for the plain loader.
//
// Ports:
//   clk         system clock, rising edge
//   reset       synchronous active-high reset
//   byte_data   incoming stream byte
//   byte_valid  byte_data is valid
//   byte_ready  loader accepts a byte this cycle
//   mem_we      word write strobe (registered, one cycle per word)
//   mem_addr    word address of the write (registered)
//   mem_wdata   word written (registered)
//   core_reset  holds the core in reset while high
//   done        image fully loaded, sticky until reset
//   error       frame rejected, sticky until reset

module program_memory_loader #(
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            byte_data,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  core_reset,
  output logic                  done,
  output logic                  error
);

  localparam logic [2:0] StLenLo = 3'd0;
  localparam logic [2:0] StLenHi = 3'd1;
  localparam logic [2:0] StData  = 3'd2;
  localparam logic [2:0] StWrite = 3'd3;
  localparam logic [2:0] StDone  = 3'd4;
  localparam logic [2:0] StError = 3'd5;
`ifdef LOADER_CHECKSUM_EN
  localparam logic [2:0] StCheck = 3'd6;
  // State entered once the data (possibly none) has been consumed.
  localparam logic [2:0] StLast  = StCheck;
`else
  localparam logic [2:0] StLast  = StDone;
`endif

  // Largest legal word count; 33 bits so the comparison never overflows.
  localparam logic [32:0] Capacity = 33'd1 << ADDR_WIDTH;

  logic [2:0]            state_q, state_d;
  logic [15:0]           n_q, n_d;
  logic [1:0]            byte_idx_q, byte_idx_d;
  logic [ADDR_WIDTH-1:0] word_cnt_q, word_cnt_d;
  // Holds the first three bytes of the current word; the fourth comes straight
  // from byte_data when the write is issued.
  logic [23:0]           asm_q, asm_d;
  logic                  mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_d;
  logic [31:0]           mem_wdata_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]            csum_q, csum_d;
`endif

  logic        accept;
  logic [15:0] n_full;
  logic        last_word;

  always_comb begin
    byte_ready = 1'b0;
    if (!reset) begin
      unique case (state_q)
        StLenLo, StLenHi, StData: byte_ready = 1'b1;
`ifdef LOADER_CHECKSUM_EN
        StCheck:                  byte_ready = 1'b1;
`endif
        default:                  byte_ready = 1'b0;
      endcase
    end
  end

  assign core_reset = (state_q != StDone);
  assign done       = (state_q == StDone);
  assign error      = (state_q == StError);

  assign accept    = byte_valid && byte_ready;
  assign n_full    = {byte_data, n_q[7:0]};
  assign last_word = (33'(word_cnt_q) == (33'(n_q) - 33'd1));

  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    byte_idx_d  = byte_idx_q;
    word_cnt_d  = word_cnt_q;
    asm_d       = asm_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
`ifdef LOADER_CHECKSUM_EN
    csum_d      = csum_q;
`endif
    case (state_q)
      StLenLo: begin
        if (accept) begin
          n_d     = {n_q[15:8], byte_data};
          state_d = StLenHi;
        end
      end
      StLenHi: begin
        if (accept) begin
          n_d = n_full;
          if (n_full == 16'd0) begin
            state_d = StLast;
          end else if (33'(n_full) > Capacity) begin
            state_d = StError;
          end else begin
            state_d = StData;
          end
        end
      end
      StData: begin
        if (accept) begin
          asm_d      = {byte_data, asm_q[23:8]};
          byte_idx_d = byte_idx_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
          csum_d     = csum_q ^ byte_data;
`endif
          if (byte_idx_q == 2'd3) begin
            state_d     = StWrite;
            mem_we_d    = 1'b1;
            mem_addr_d  = word_cnt_q;
            mem_wdata_d = {byte_data, asm_q};
          end
        end
      end
      StWrite: begin
        if (last_word) begin
          state_d = StLast;
        end else begin
          word_cnt_d = word_cnt_q + 1'b1;
          state_d    = StData;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      StCheck: begin
        if (accept) begin
          state_d = (byte_data == csum_q) ? StDone : StError;
        end
      end
`endif
      StDone, StError: begin
        state_d = state_q;
      end
      default: begin
        state_d = StError;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StLenLo;
      n_q        <= '0;
      byte_idx_q <= '0;
      word_cnt_q <= '0;
      asm_q      <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      byte_idx_q <= byte_idx_d;
      word_cnt_q <= word_cnt_d;
      asm_q      <= asm_d;
      mem_we     <= mem_we_d;
      mem_addr   <= mem_addr_d;
      mem_wdata  <= mem_wdata_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

endmodule

// File: tb/tb_program_memory_loader.sv
// Bench for program_memory_loader: directed frames, a byte-count based model
// checked every cycle, and literal checks on the captured memory writes.

module tb_program_memory_loader;

  localparam int unsigned AW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [7:0]    byte_data = 8'h00;
  logic          byte_valid = 1'b0;
  logic          byte_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          core_reset;
  logic          done;
  logic          error;

  always #5 clk = ~clk;

  program_memory_loader #(.ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .core_reset (core_reset),
    .done       (done),
    .error      (error)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Log of every write the DUT performs.
  int          wr_count = 0;
  logic [31:0] log_addr [4096];
  logic [31:0] log_data [4096];
  always @(negedge clk) begin
    if (mem_we) begin
      log_addr[wr_count] <= 32'(mem_addr);
      log_data[wr_count] <= mem_wdata;
      wr_count           <= wr_count + 1;
    end
  end

  // Model: tracks how many bytes have been accepted and derives everything
  // from the frame layout (byte 1/2 = length, then 4 bytes per word).
  int          m_acc, m_n, m_wr, m_k, m_addr;
  bit          m_stall, m_done, m_err, m_chk, m_we;
  logic [7:0]  m_xor;
  logic [31:0] m_word, m_wdata;

  task automatic finish_data();
`ifdef LOADER_CHECKSUM_EN
    m_chk = 1;
`else
    m_done = 1;
`endif
  endtask

  function automatic bit m_ready();
    return !reset && !m_done && !m_err && !m_stall;
  endfunction

  task automatic model_step();
    bit rdy;
    rdy = m_ready();
    if (reset) begin
      m_acc = 0; m_n = 0; m_wr = 0; m_stall = 0; m_done = 0; m_err = 0;
      m_chk = 0; m_we = 0; m_xor = 8'h00; m_word = 32'h0;
      return;
    end
    m_we = 0;
    if (m_stall) begin
      m_stall = 0;
      if (m_wr == m_n) finish_data();
    end else if (byte_valid && rdy) begin
      m_acc++;
      if (m_acc == 1) begin
        m_n = int'(byte_data);
      end else if (m_acc == 2) begin
        m_n = m_n + (int'(byte_data) << 8);
        if (m_n == 0) finish_data();
        else if (m_n > (1 << AW)) m_err = 1;
      end else if (m_chk) begin
        m_chk = 0;
        if (byte_data == m_xor) m_done = 1;
        else m_err = 1;
      end else begin
        m_k = m_acc - 3;
        m_xor = m_xor ^ byte_data;
        m_word[8*(m_k%4) +: 8] = byte_data;
        if (m_k % 4 == 3) begin
          m_we = 1; m_addr = m_k / 4; m_wdata = m_word; m_wr++; m_stall = 1;
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Per-cycle comparison against the model.
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk("byte_ready", 32'(byte_ready), 32'(m_ready()));
      chk("mem_we", 32'(mem_we), 32'(m_we));
      if (m_we) begin
        chk("mem_addr", 32'(mem_addr), m_addr);
        chk("mem_wdata", mem_wdata, m_wdata);
      end
      chk("done", 32'(done), 32'(m_done));
      chk("error", 32'(error), 32'(m_err));
      chk("core_reset", 32'(core_reset), 32'(!m_done));
    end
  end

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    byte_valid = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    bit acc;
    acc = 0;
    byte_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    byte_valid = 1'b1;
    byte_data  = b;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk);
      acc = byte_ready;
      @(posedge clk);
      #1;
    end
    byte_valid = 1'b0;
    if (!acc) begin
      n_checks++;
      $display("FAIL send: byte 0x%0h not accepted within 20 cycles", b);
    end
  endtask

  // Present a byte for a few cycles; it must never be taken.
  task automatic offer(input logic [7:0] b, input int cycles);
    byte_valid = 1'b1;
    byte_data  = b;
    repeat (cycles) begin
      @(negedge clk);
      chk("ignored_ready", 32'(byte_ready), 32'h0);
      @(posedge clk);
      #1;
    end
    byte_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] fr[$], input int gap_mod);
    for (int i = 0; i < fr.size(); i++) send(fr[i], (gap_mod == 0) ? 0 : (i % gap_mod));
  endtask

  function automatic logic [7:0] xor_data(input logic [7:0] fr[$]);
    logic [7:0] x;
    x = 8'h00;
    for (int i = 2; i < fr.size(); i++) x = x ^ fr[i];
    return x;
  endfunction

  logic [7:0] directed[$];
  logic [7:0] big[$];
  int base;

  initial begin
    directed = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};

    // Reset state
    @(negedge clk);
    chk("rst_byte_ready", 32'(byte_ready), 32'h0);
    do_reset(2);
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    chk("rst_mem_addr", 32'(mem_addr), 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_core_reset", 32'(core_reset), 32'h1);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_error", 32'(error), 32'h0);

    // Directed load, byte_valid held high
    base = wr_count;
    send_frame(directed, 0);
`ifdef LOADER_CHECKSUM_EN
    send(xor_data(directed), 0);
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("dir_count", wr_count - base, 2);
    chk("dir_addr0", log_addr[base], 32'h0);
    chk("dir_data0", log_data[base], 32'h0000_0013);
    chk("dir_addr1", log_addr[base+1], 32'h1);
    chk("dir_data1", log_data[base+1], 32'h0010_0093);
    chk("dir_done", 32'(done), 32'h1);
    chk("dir_core_reset", 32'(core_reset), 32'h0);
    offer(8'hAA, 3);
    chk("dir_no_extra", wr_count - base, 2);

    // Empty image
    do_reset(1);
    base = wr_count;
    send(8'h00, 0);
    send(8'h00, 0);
`ifdef LOADER_CHECKSUM_EN
    send(8'h00, 0);
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("empty_count", wr_count - base, 0);
    chk("empty_done", 32'(done), 32'h1);

    // Gaps between bytes, valid held across WRITE on some bytes
    do_reset(1);
    base = wr_count;
    send_frame(directed, 3);
`ifdef LOADER_CHECKSUM_EN
    send(xor_data(directed), 1);
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("gap_count", wr_count - base, 2);
    chk("gap_data0", log_data[base], 32'h0000_0013);
    chk("gap_data1", log_data[base+1], 32'h0010_0093);
    chk("gap_done", 32'(done), 32'h1);

    // Oversize length (N = 257)
    do_reset(1);
    base = wr_count;
    send(8'h01, 0);
    send(8'h01, 0);
    offer(8'h13, 4);
    chk("over_error", 32'(error), 32'h1);
    chk("over_done", 32'(done), 32'h0);
    chk("over_core_reset", 32'(core_reset), 32'h1);
    chk("over_count", wr_count - base, 0);

    // Reset in the middle of the first word
    do_reset(1);
    base = wr_count;
    send(8'h02, 0);
    send(8'h00, 0);
    send(8'h13, 0);
    send(8'h00, 0);
    do_reset(1);
    send_frame(directed, 0);
`ifdef LOADER_CHECKSUM_EN
    send(xor_data(directed), 0);
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("abort_count", wr_count - base, 2);
    chk("abort_addr0", log_addr[base], 32'h0);
    chk("abort_data0", log_data[base], 32'h0000_0013);
    chk("abort_data1", log_data[base+1], 32'h0010_0093);
    chk("abort_done", 32'(done), 32'h1);

    // Full capacity (N = 256): last write lands on address 255
    big = '{8'h00, 8'h01};
    for (int i = 0; i < 256; i++) begin
      big.push_back(8'(i));
      big.push_back(8'(i) ^ 8'h5A);
      big.push_back(8'hC3);
      big.push_back(8'h00);
    end
    do_reset(1);
    base = wr_count;
    send_frame(big, 0);
`ifdef LOADER_CHECKSUM_EN
    send(xor_data(big), 0);
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("full_count", wr_count - base, 256);
    chk("full_last_addr", log_addr[base+255], 32'd255);
    chk("full_last_data", log_data[base+255], 32'h00C3_A5FF);
    chk("full_done", 32'(done), 32'h1);

`ifdef LOADER_CHECKSUM_EN
    // Wrong checksum: words stay written, frame rejected
    do_reset(1);
    base = wr_count;
    send_frame(directed, 0);
    send(xor_data(directed) ^ 8'h01, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("csum_bad_error", 32'(error), 32'h1);
    chk("csum_bad_core_reset", 32'(core_reset), 32'h1);
    chk("csum_bad_count", wr_count - base, 2);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
